spike_rate_decoder: RTL and testbench

Reader side of the neuron spike interface. It takes the 1-bit spike outputs of NUM_CH neurons and counts spikes per channel over a fixed window of WINDOW enabled clock cycles. At the end of each window it publishes the per-channel rates and the index of the most active neuron (the winner) over a valid/ready handshake. It sits after the neuron layer and feeds the classification/readout logic.

---
 rtl/snn_pkg.sv | 13 +
 rtl/spike_counter.sv | 30 +++
 rtl/spike_rate_decoder.sv | 118 +++++++++++
 tb/tb_spike_rate_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-neuron layer and its rate decoder.
package snn_pkg;
  localparam int SNN_NUM_CH = 2;
  localparam int SNN_WINDOW = 16;
  localparam int SNN_CNT_W  = 8;

  typedef logic [SNN_CNT_W-1:0] spike_cnt_t;

  typedef enum logic {
    CNT_IDLE  = 1'b0,
    CNT_COUNT = 1'b1
  } cnt_state_e;
endpackage

// File: rtl/spike_counter.sv
// Per-channel saturating spike counter; sum_o is the count including this cycle's spike.
module spike_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = SNN_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] sum_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sum_o = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) sum_o = cnt_q + CNT_W'(1);
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = sum_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per channel over a WINDOW-cycle window and publishes counts plus
// the most active channel over a valid/ready handshake.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter  int NUM_CH = SNN_NUM_CH,
  parameter  int WINDOW = SNN_WINDOW,
  parameter  int CNT_W  = SNN_CNT_W,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WIN_W  = $clog2(WINDOW)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       spike_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*CNT_W-1:0] cnt_out,
  output logic [IDX_W-1:0]        winner,
  output logic                    none,
  output logic                    overrun
);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  cnt_state_e              state;
  logic [WIN_W-1:0]        win_q, win_d;
  logic                    win_end, ctr_clr, load;
  logic [NUM_CH*CNT_W-1:0] sum_w, cnt_q;
  logic [CNT_W-1:0]        best;
  logic [IDX_W-1:0]        winner_d, winner_q;
  logic                    none_d, none_q;
  logic                    valid_d, valid_q, over_d, over_q;

  // The counting state is carried directly by en; no separate state register.
  always_comb state = en ? CNT_COUNT : CNT_IDLE;

  always_comb begin
    win_d   = win_q;
    win_end = 1'b0;
    ctr_clr = clear;
    if (clear) begin
      win_d = '0;
    end else begin
      case (state)
        CNT_COUNT: begin
          if (win_q == WIN_LAST) begin
            win_end = 1'b1;
            ctr_clr = 1'b1;
            win_d   = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
          end
        end
        default: win_d = win_q;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spike_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (state == CNT_COUNT),
      .clr_i (ctr_clr),
      .inc_i (spike_in[g]),
      .sum_o (sum_w[g*CNT_W +: CNT_W])
    );
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best     = sum_w[CNT_W-1:0];
    winner_d = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (sum_w[i*CNT_W +: CNT_W] > best) begin
        best     = sum_w[i*CNT_W +: CNT_W];
        winner_d = IDX_W'(i);
      end
    end
    none_d = (sum_w == '0);
  end

  // A finished window loads only if the output slot is free or being emptied this edge.
  always_comb begin
    load    = win_end && (!valid_q || out_ready);
    valid_d = valid_q;
    if (load)                        valid_d = 1'b1;
    else if (valid_q && out_ready)   valid_d = 1'b0;
    over_d = over_q | (win_end && valid_q && !out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      cnt_q    <= '0;
      winner_q <= '0;
      none_q   <= 1'b0;
      valid_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      win_q   <= win_d;
      valid_q <= valid_d;
      over_q  <= over_d;
      if (load) begin
        cnt_q    <= sum_w;
        winner_q <= winner_d;
        none_q   <= none_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign cnt_out   = cnt_q;
  assign winner    = winner_q;
  assign none      = none_q;
  assign overrun   = over_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: window-level vector table, scoreboard model, corner sequences.
module tb_spike_rate_decoder;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clear, out_ready;
  logic [1:0]  spike_in;
  logic        out_valid, winner, none, overrun;
  logic [15:0] cnt_out;

  logic        s_en, s_valid, s_winner, s_none, s_over;
  logic [1:0]  s_spike;
  logic [5:0]  s_cnt;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NUM_CH(2), .WINDOW(W), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .spike_in(spike_in),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_out(cnt_out),
    .winner(winner), .none(none), .overrun(overrun)
  );

  spike_rate_decoder #(.NUM_CH(2), .WINDOW(16), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(s_en), .clear(1'b0), .spike_in(s_spike),
    .out_valid(s_valid), .out_ready(1'b0), .cnt_out(s_cnt),
    .winner(s_winner), .none(s_none), .overrun(s_over)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int          m_win, m_c0, m_c1;
  logic        m_valid, m_over;
  logic [17:0] exp_q[$];

  function automatic int sat8(input int c, input logic s);
    return (s && c < 255) ? c + 1 : c;
  endfunction

  task automatic model_reset();
    m_win = 0; m_c0 = 0; m_c1 = 0; m_valid = 1'b0; m_over = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input logic e, input logic c, input logic [1:0] sp, input logic r);
    int n0, n1;
    logic acc, ld;
    logic [17:0] res;
    @(negedge clk);
    en = e; clear = c; spike_in = sp; out_ready = r;
    chk("valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("overrun", {31'd0, overrun}, {31'd0, m_over});
    if (m_valid) begin
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("result", {14'd0, cnt_out, winner, none}, {14'd0, exp_q[0]});
      if (r && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    acc = m_valid && r;
    ld  = 1'b0;
    if (c) begin
      m_win = 0; m_c0 = 0; m_c1 = 0;
    end else if (e) begin
      n0 = sat8(m_c0, sp[0]);
      n1 = sat8(m_c1, sp[1]);
      if (m_win == W - 1) begin
        res = {8'(n1), 8'(n0), (n1 > n0) ? 1'b1 : 1'b0, (n0 == 0 && n1 == 0) ? 1'b1 : 1'b0};
        if (!m_valid || r) begin
          ld = 1'b1;
          exp_q.push_back(res);
        end else begin
          m_over = 1'b1;
        end
        m_win = 0; m_c0 = 0; m_c1 = 0;
      end else begin
        m_win++; m_c0 = n0; m_c1 = n1;
      end
    end
    m_valid = ld ? 1'b1 : (acc ? 1'b0 : m_valid);
  endtask

  task automatic run_win(input logic [7:0] m0, input logic [7:0] m1, input logic r_all, input logic r_last);
    for (int c = 0; c < W; c++) step(1'b1, 1'b0, {m1[c], m0[c]}, (c == W - 1) ? r_last : r_all);
  endtask

  task automatic post_chk(input string nm, input logic [7:0] c0, input logic [7:0] c1,
                          input logic w, input logic n);
    @(posedge clk); #1;
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(nm, {14'd0, cnt_out, winner, none}, {14'd0, c1, c0, w, n});
  endtask

  typedef struct {
    logic [7:0] m0, m1, c0, c1;
    logic       w, n;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{8'hFF, 8'h55, 8'd8, 8'd4, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h00, 8'd0, 8'd0, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 8'h07, 8'd0, 8'd3, 1'b1, 1'b0};
    tbl[3] = '{8'h0F, 8'h0F, 8'd4, 8'd4, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 8'h03, 8'd1, 8'd2, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h00, 8'd1, 8'd0, 1'b0, 1'b0};

    rst_n = 1'b0; en = 1'b0; clear = 1'b0; out_ready = 1'b0; spike_in = '0;
    s_en = 1'b0; s_spike = '0;
    model_reset();
    #12;
    chk("rst_state", {12'd0, out_valid, cnt_out, winner, none, overrun}, 32'd0);
    chk("rst_state_sat", {22'd0, s_valid, s_cnt, s_winner, s_none, s_over}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation instance: 16 cycles of all-high spikes on a 3-bit counter.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      s_en = 1'b1; s_spike = 2'b11;
      if (i == 15) chk("sat_early", {31'd0, s_valid}, 32'd0);
    end
    @(posedge clk); #1;
    chk("sat_valid", {31'd0, s_valid}, 32'd1);
    chk("sat_result", {23'd0, s_cnt, s_winner, s_none, s_over}, {23'd0, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    s_en = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_win(tbl[k].m0, tbl[k].m1, 1'b1, 1'b1);
      post_chk($sformatf("vec%0d", k), tbl[k].c0, tbl[k].c1, tbl[k].w, tbl[k].n);
    end

    // Acceptance and a new load on the same edge.
    run_win(8'h03, 8'h1F, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("same_edge_valid", {31'd0, out_valid}, 32'd1);
    chk("same_edge_overrun", {31'd0, overrun}, 32'd0);
    chk("same_edge_result", {14'd0, cnt_out, winner, none}, {14'd0, 8'd5, 8'd2, 1'b1, 1'b0});

    // Backpressure across two window ends.
    step(1'b0, 1'b0, 2'b00, 1'b1);
    run_win(8'h3F, 8'h01, 1'b0, 1'b0);
    post_chk("hold_first", 8'd6, 8'd1, 1'b0, 1'b0);
    run_win(8'h00, 8'hFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    chk("held_result", {14'd0, cnt_out, winner, none}, {14'd0, 8'd1, 8'd6, 1'b0, 1'b0});
    step(1'b0, 1'b0, 2'b00, 1'b1);
    @(posedge clk); #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // en gap mid-window: spikes during the gap must be ignored.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b01, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b01, 1'b1);
    post_chk("en_gap", 8'd8, 8'd0, 1'b0, 1'b0);

    // clear at cycle 4 discards the partial window.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b10, 1'b1);
    step(1'b1, 1'b1, 2'b11, 1'b1);
    run_win(8'h0F, 8'h01, 1'b1, 1'b1);
    post_chk("clear_abort", 8'd4, 8'd1, 1'b0, 1'b0);

    // Asynchronous reset mid-window with a result held.
    run_win(8'hFF, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {12'd0, out_valid, cnt_out, winner, none, overrun}, 32'd0);
    @(negedge clk);
    en = 1'b0; clear = 1'b0; out_ready = 1'b0; spike_in = '0;
    rst_n = 1'b1;
    model_reset();
    run_win(8'h00, 8'hAA, 1'b1, 1'b1);
    post_chk("post_rst", 8'd0, 8'd4, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
